sync2async_tx: RTL and testbench

Clocked-to-asynchronous transmit bridge. It accepts words from a synchronous valid/ready stream and buffers them in a small FIFO. It emits each word as a 4-phase bundled-data handshake (`req_o`/`ack_i`) that drives the first Muller C-element stage of the self-timed pipeline. It is the synchronous producer sitting directly upstream of the C-element chain, which shares its `rstn`.

---
 rtl/async_pkg.sv | 15 +
 rtl/sync_ff.sv | 23 ++
 rtl/sync2async_tx.sv | 137 +++++++++++++
 tb/tb_sync2async_tx.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/async_pkg.sv
// rtl/async_pkg.sv - shared types and 4-phase handshake constants for the async bridges
package async_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } tx_state_t;

  // Level of req/ack in the two halves of a 4-phase cycle
  localparam logic HS_ASSERT  = 1'b1;
  localparam logic HS_RELEASE = 1'b0;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-flop synchronizer chain, asynchronous active-low reset to 0
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/sync2async_tx.sv
// rtl/sync2async_tx.sv - valid/ready stream to 4-phase bundled-data transmit bridge
module sync2async_tx
  import async_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int DEPTH       = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              req_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              ack_i,
  output logic              busy_o,
  output logic              err_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int WD_W  = $clog2(TIMEOUT + 2);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [WD_W-1:0]   wd;
  tx_state_t         state, state_nxt;
  logic              push, pop, req_nxt, ack_s, nonempty, in_wait, enter_wait;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  sync_ff #(.STAGES(SYNC_STAGES)) u_ack_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (ack_i),
    .q    (ack_s)
  );

  // Registered count only: a pop never frees a slot in the same cycle
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid & in_ready;
  assign nonempty = (count != '0);
  assign busy_o   = (state != IDLE) | nonempty;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_o;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        if (nonempty) begin
          pop       = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP: begin
        req_nxt   = HS_ASSERT;
        state_nxt = WAIT_HI;
      end
      WAIT_HI: begin
        if (ack_s == HS_ASSERT) begin
          req_nxt   = HS_RELEASE;
          state_nxt = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // Chain straight into the next word without passing through IDLE
        if (ack_s == HS_RELEASE) begin
          if (nonempty) begin
            pop       = 1'b1;
            state_nxt = SETUP;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state  <= IDLE;
      req_o  <= HS_RELEASE;
      data_o <= '0;
    end else begin
      state <= state_nxt;
      req_o <= req_nxt;
      if (pop) data_o <= mem[rd_ptr];
    end
  end

  assign in_wait    = (state == WAIT_HI) || (state == WAIT_LO);
  assign enter_wait = (state_nxt != state) && ((state_nxt == WAIT_HI) || (state_nxt == WAIT_LO));

  // Timeout only flags; the handshake is never abandoned
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd    <= '0;
      err_o <= 1'b0;
    end else begin
      if (enter_wait) begin
        wd <= '0;
      end else if (in_wait && (wd != WD_W'(TIMEOUT))) begin
        wd <= wd + WD_W'(1);
      end
      if ((TIMEOUT != 0) && in_wait && ((wd + WD_W'(1)) == WD_W'(TIMEOUT))) begin
        err_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sync2async_tx.sv
// tb/tb_sync2async_tx.sv - scoreboard bench for sync2async_tx with a reactive 4-phase ack model
module tb_sync2async_tx;

  localparam int DATA_W  = 8;
  localparam int DEPTH   = 2;
  localparam int SYNC    = 2;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              req_o;
  logic [DATA_W-1:0] data_o;
  logic              ack_i = 1'b0;
  logic              busy_o;
  logic              err_o;

  sync2async_tx #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (SYNC),
    .TIMEOUT     (TIMEOUT)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .req_o    (req_o),
    .data_o   (data_o),
    .ack_i    (ack_i),
    .busy_o   (busy_o),
    .err_o    (err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rx_count = 0;
  logic [DATA_W-1:0] exp_q [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait budget expired (cycle %0d)", name, cyc);
  endtask

  // Pipeline-side ack: follows req_o after a delay, held low while in reset
  bit ack_hold = 1'b0;
  bit ack_rand = 1'b0;
  int ack_delay = 3;
  int cur_delay = 3;
  int acnt = 0;
  int ack_rise_cyc = 0;
  int ack_fall_cyc = -1;

  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        ack_i = 1'b0;
        acnt = 0;
      end else if (!ack_hold && (req_o != ack_i)) begin
        if (acnt >= cur_delay) begin
          ack_i = req_o;
          if (req_o) ack_rise_cyc = cyc;
          else       ack_fall_cyc = cyc;
          acnt = 0;
          cur_delay = ack_rand ? int'($urandom_range(10, 0)) : ack_delay;
        end else begin
          acnt++;
        end
      end else begin
        acnt = 0;
      end
    end
  end

  // Synchronized ack as the bridge is meant to see it: ack_i delayed SYNC edges
  logic [SYNC-1:0] ack_seen;
  always @(posedge clk or negedge rstn) begin
    if (!rstn) ack_seen <= '0;
    else       ack_seen <= {ack_seen[SYNC-2:0], ack_i};
  end

  // Monitor: compares each word as its request rises, plus handshake timing
  logic              prev_req = 1'b0;
  logic              prev_bundle = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;
  bit                nobubble = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (prev_bundle) check("bundled_data_stable", 32'(data_o), 32'(prev_data));
      if (!prev_req && req_o) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word_unexpected: got 0x%0h with empty scoreboard (cycle %0d)", data_o, cyc);
        end else begin
          check("word_order", 32'(data_o), 32'(exp_q.pop_front()));
        end
        rx_count++;
        if (nobubble && ack_fall_cyc >= 0) check("no_bubble_gap", cyc - ack_fall_cyc, SYNC + 2);
      end
      if (prev_req && !req_o) check("req_fall_latency", cyc - ack_rise_cyc, SYNC + 1);
    end
    prev_req    = req_o;
    prev_data   = data_o;
    prev_bundle = req_o | ack_seen[SYNC-1];
  end

  // Caller is at a negedge; returns at the negedge after the accepting edge
  task automatic push_word(input logic [DATA_W-1:0] w);
    bit acc;
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    forever begin
      acc = in_ready;
      @(negedge clk);
      if (acc) begin
        exp_q.push_back(w);
        break;
      end
      if (++n > 300) begin
        fail_timeout("push_accept");
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_busy_low(input int budget);
    int n = 0;
    while (busy_o && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy_o) fail_timeout("busy_release");
  endtask

  task automatic wait_req(input logic val, input int budget);
    int n = 0;
    while (req_o !== val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (req_o !== val) fail_timeout("req_level");
  endtask

  task automatic wait_rx(input int target, input int budget);
    int n = 0;
    while (rx_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (rx_count < target) fail_timeout("rx_count");
  endtask

  initial begin
    #900000;
    $display("FAIL global_time_limit: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int base;

    // Reset values under random inputs
    repeat (5) begin
      @(negedge clk);
      in_valid = 1'($urandom_range(1, 0));
      in_data  = DATA_W'($urandom);
      check("rst_req", 32'(req_o), 0);
      check("rst_data", 32'(data_o), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_busy", 32'(busy_o), 0);
      check("rst_err", 32'(err_o), 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rstn = 1'b1;

    // Single transfer
    @(negedge clk);
    push_word(8'hA5);
    check("single_data_pre", 32'(data_o), 0);
    @(negedge clk);
    check("single_data_setup", 32'(data_o), 32'hA5);
    check("single_req_setup", 32'(req_o), 0);
    @(negedge clk);
    check("single_req_rise", 32'(req_o), 1);
    wait_busy_low(200);
    check("single_busy_latency", cyc - ack_fall_cyc, SYNC + 1);

    // Back-to-back words, FIFO fills while the first is in flight
    @(negedge clk);
    ack_fall_cyc = -1;
    nobubble = 1'b1;
    base = rx_count;
    push_word(8'h11);
    push_word(8'h22);
    push_word(8'h33);
    check("b2b_full_ready", 32'(in_ready), 0);
    check("b2b_busy", 32'(busy_o), 1);
    push_word(8'h44);
    wait_rx(base + 4, 500);
    wait_busy_low(200);
    nobubble = 1'b0;
    check("b2b_drained", exp_q.size(), 0);

    // Watchdog: ack withheld, err rises after TIMEOUT cycles in WAIT_HI
    ack_hold = 1'b1;
    @(negedge clk);
    push_word(8'h3C);
    wait_req(1'b1, 20);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("timeout_err_early", 32'(err_o), 0);
    @(negedge clk);
    check("timeout_err_set", 32'(err_o), 1);
    check("timeout_req_held", 32'(req_o), 1);
    ack_hold = 1'b0;
    wait_busy_low(200);
    check("timeout_err_sticky", 32'(err_o), 1);
    #2 rstn = 1'b0;
    #1 check("timeout_err_cleared", 32'(err_o), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Reset while in WAIT_LO with two words queued
    @(negedge clk);
    push_word(8'h01);
    push_word(8'h02);
    push_word(8'h03);
    wait_req(1'b1, 20);
    wait_req(1'b0, 50);
    check("midrst_full_before", 32'(in_ready), 0);
    #2 rstn = 1'b0;
    #1;
    check("midrst_req", 32'(req_o), 0);
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_busy", 32'(busy_o), 0);
    check("midrst_data", 32'(data_o), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    base = rx_count;
    push_word(8'h5A);
    wait_rx(base + 1, 200);
    wait_busy_low(200);
    check("midrst_drained", exp_q.size(), 0);

    // Random traffic with random ack delays
    ack_rand  = 1'b1;
    cur_delay = int'($urandom_range(10, 0));
    base = rx_count;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(3, 0)) @(negedge clk);
      push_word(DATA_W'($urandom));
    end
    wait_rx(base + 1000, 40000);
    wait_busy_low(500);
    check("rand_count", rx_count - base, 1000);
    check("rand_drained", exp_q.size(), 0);
    check("rand_no_err", 32'(err_o), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
